// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Optional leading-zero blank outputs with `define BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         ready,
    output logic         done_tick,
    output logic [3:0]   bcd3,
    output logic [3:0]   bcd2,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd0,
    output logic         overflow
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [3:0]   blank
`endif
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MAXV = W'(14'd9999);

    typedef enum logic [1:0] {
        IDLE,
        OP,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  shift_reg, shift_nxt;
    logic [15:0]   bcd_acc, bcd_adj, bcd_nxt;
    logic [CW-1:0] cnt;
    logic          ovf, in_ovf, last_iter;

`ifdef BIN2BCD_BLANK_EN
    logic [3:0] blank_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = OP;
            OP:      if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        done_tick = (state == DONE);
    end

    // Add-3 correction on every nibble, then shift the whole chain left.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4];
        end
        {bcd_nxt, shift_nxt} = {bcd_adj, shift_reg} << 1;
        in_ovf    = 32'(bin) > 32'd9999;
        last_iter = (cnt == CW'(1));
    end

`ifdef BIN2BCD_BLANK_EN
    always_comb begin
        blank_nxt    = 4'b0000;
        blank_nxt[3] = (bcd_nxt[15:12] == 4'd0);
        blank_nxt[2] = blank_nxt[3] && (bcd_nxt[11:8] == 4'd0);
        blank_nxt[1] = blank_nxt[2] && (bcd_nxt[7:4] == 4'd0);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bcd_acc   <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            bcd3      <= 4'd0;
            bcd2      <= 4'd0;
            bcd1      <= 4'd0;
            bcd0      <= 4'd0;
            overflow  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank     <= 4'b1110;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= in_ovf ? MAXV : bin;
                        ovf       <= in_ovf;
                        bcd_acc   <= '0;
                        cnt       <= CW'(W);
                    end
                end
                OP: begin
                    shift_reg <= shift_nxt;
                    bcd_acc   <= bcd_nxt;
                    cnt       <= cnt - CW'(1);
                    // Final shift lands directly in the output registers.
                    if (last_iter) begin
                        bcd3     <= bcd_nxt[15:12];
                        bcd2     <= bcd_nxt[11:8];
                        bcd1     <= bcd_nxt[7:4];
                        bcd0     <= bcd_nxt[3:0];
                        overflow <= ovf;
`ifdef BIN2BCD_BLANK_EN
                        blank    <= blank_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (W=14).
// Blank checks are compiled in with `define BIN2BCD_BLANK_EN.
module tb_bin2bcd_seq;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] bin;
    logic         ready;
    logic         done_tick;
    logic [3:0]   bcd3, bcd2, bcd1, bcd0;
    logic         overflow;
`ifdef BIN2BCD_BLANK_EN
    logic [3:0]   blank;
`endif

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.W(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bin(bin),
        .ready(ready),
        .done_tick(done_tick),
        .bcd3(bcd3),
        .bcd2(bcd2),
        .bcd1(bcd1),
        .bcd0(bcd0),
        .overflow(overflow)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank(blank)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] ed,
                             input logic eo, input logic [3:0] eb);
        check({tag, "_bcd"}, {bcd3, bcd2, bcd1, bcd0}, ed);
        check({tag, "_ovf"}, overflow, eo);
`ifdef BIN2BCD_BLANK_EN
        check({tag, "_blank"}, blank, eb);
`else
        if (eb !== 4'bxxxx) begin end
`endif
    endtask

    // One conversion; latency counts the accept cycle through the done cycle.
    task automatic conv(input string tag, input int v, input logic [15:0] ed,
                        input logic eo, input logic [3:0] eb);
        int n;
        @(negedge clk);
        bin   = W'(v);
        start = 1'b1;
        check({tag, "_ready_in"}, ready, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = ~bin;
        n = 2;
        while (!done_tick && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, W + 2);
        check({tag, "_ready_done"}, ready, 1'b0);
        check_out(tag, ed, eo, eb);
        @(posedge clk);
        #1;
        check({tag, "_tick_1cyc"}, done_tick, 1'b0);
        check({tag, "_idle"}, ready, 1'b1);
    endtask

    initial begin
        int ticks;
        int cyc;
        int nd;
        int nrdy;
        int d[3];

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_done", done_tick, 1'b0);
        check_out("rst", 16'h0000, 1'b0, 4'b1110);
        @(negedge clk);
        reset = 1'b0;

        conv("v0", 0, 16'h0000, 1'b0, 4'b1110);
        conv("v1234", 1234, 16'h1234, 1'b0, 4'b0000);
        conv("v9999", 9999, 16'h9999, 1'b0, 4'b0000);
        conv("v16383", 16383, 16'h9999, 1'b1, 4'b0000);
        conv("v7", 7, 16'h0007, 1'b0, 4'b1110);

        // A start pulse during OP must be ignored.
        @(negedge clk);
        bin   = W'(42);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        bin   = W'(8888);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ticks = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_tick) ticks++;
        end
        check("ign_ticks", ticks, 1);
        check_out("ign_hold", 16'h0042, 1'b0, 4'b1100);
        check("ign_idle", ready, 1'b1);

        // Start held high: back-to-back conversions.
        @(negedge clk);
        bin   = W'(305);
        start = 1'b1;
        cyc  = 0;
        nd   = 0;
        nrdy = 0;
        while (nd < 3 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (nd > 0 && ready) nrdy++;
            if (done_tick) begin
                d[nd] = cyc;
                nd++;
                check_out("b2b", 16'h0305, 1'b0, 4'b1000);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_count", nd, 3);
        check("b2b_period1", d[1] - d[0], W + 2);
        check("b2b_period2", d[2] - d[1], W + 2);
        check("b2b_ready_cycles", nrdy, 2);
        cyc = 0;
        while (!ready && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("b2b_back_idle", ready, 1'b1);

        // Reset in the middle of a conversion.
        conv("v1111", 1111, 16'h1111, 1'b0, 4'b0000);
        @(negedge clk);
        bin   = W'(5678);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_done", done_tick, 1'b0);
        check_out("abort", 16'h0000, 1'b0, 4'b1110);
        @(negedge clk);
        reset = 1'b0;
        ticks = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done_tick) ticks++;
        end
        check("abort_no_tick", ticks, 0);
        conv("v5678", 5678, 16'h5678, 1'b0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
